// File: rtl/rom_fetch_unit.sv
// Instruction fetch stage: turns core ROMcs/ROMrd strobes into ROM req/ack cycles,
// keeps a one-entry address tag, aborts on ROM timeout and counts EOI strobes.
module rom_fetch_unit #(
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter logic [7:0]  NOP_OPCODE   = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] program_addr,
    input  logic        rom_cs,
    input  logic        rom_rd,
    input  logic        eoi,
    input  logic        flush,
    output logic [7:0]  instruction,
    output logic        instr_valid,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic [15:0] instr_count,
    output logic        fetch_err
);

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(WAIT_TIMEOUT);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_next;
    logic        rom_rd_q, eoi_q;
    logic [15:0] last_addr, last_addr_next;
    logic [15:0] tag_addr, tag_addr_next;
    logic [7:0]  tag_data, tag_data_next;
    logic        tag_valid, tag_valid_next;
    logic [7:0]  wait_count, wait_count_next;
    logic [7:0]  instruction_next;
    logic        instr_valid_next;
    logic        mem_req_next;
    logic [15:0] mem_addr_next;
    logic [15:0] instr_count_next;
    logic        fetch_err_next;

    logic strobe, trigger, hit, timeout, eoi_rise;

    assign strobe   = rom_cs & rom_rd;
    assign trigger  = strobe & (~rom_rd_q | (program_addr != last_addr));
    assign hit      = tag_valid & (program_addr == tag_addr) & ~flush;
    assign eoi_rise = eoi & ~eoi_q;
    // An ack in the final wait cycle takes priority over the timeout abort.
    assign timeout  = (state == REQ) & ~mem_ack & ((wait_count + 8'd1) == TIMEOUT_LIMIT);
    assign busy     = mem_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rom_rd_q    <= 1'b0;
            eoi_q       <= 1'b0;
            last_addr   <= 16'h0000;
            tag_addr    <= 16'h0000;
            tag_data    <= 8'h00;
            tag_valid   <= 1'b0;
            wait_count  <= 8'h00;
            instruction <= NOP_OPCODE;
            instr_valid <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= 16'h0000;
            instr_count <= 16'h0000;
            fetch_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state       <= state_next;
            rom_rd_q    <= rom_rd;
            eoi_q       <= eoi;
            last_addr   <= last_addr_next;
            tag_addr    <= tag_addr_next;
            tag_data    <= tag_data_next;
            tag_valid   <= tag_valid_next;
            wait_count  <= wait_count_next;
            instruction <= instruction_next;
            instr_valid <= instr_valid_next;
            mem_req     <= mem_req_next;
            mem_addr    <= mem_addr_next;
            instr_count <= instr_count_next;
            fetch_err   <= fetch_err_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next       = state;
        last_addr_next   = last_addr;
        tag_addr_next    = tag_addr;
        tag_data_next    = tag_data;
        tag_valid_next   = tag_valid & ~flush;
        wait_count_next  = wait_count;
        instruction_next = instruction;
        instr_valid_next = instr_valid;
        mem_req_next     = mem_req;
        mem_addr_next    = mem_addr;
        instr_count_next = instr_count + {15'd0, eoi_rise};
        fetch_err_next   = (fetch_err & ~eoi_rise) | timeout;

        case (state)
            IDLE, HOLD: begin
                if (trigger) begin
                    last_addr_next = program_addr;
                    if (hit) begin
                        instruction_next = tag_data;
                        instr_valid_next = 1'b1;
                        state_next       = HOLD;
                    end else begin
                        state_next       = REQ;
                        mem_addr_next    = program_addr;
                        mem_req_next     = 1'b1;
                        instr_valid_next = 1'b0;
                        wait_count_next  = 8'h00;
                    end
                end else if (!strobe) begin
                    state_next       = IDLE;
                    instr_valid_next = 1'b0;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    // The byte is always captured, even if the core gave up on it.
                    mem_req_next   = 1'b0;
                    tag_addr_next  = mem_addr;
                    tag_data_next  = mem_data;
                    tag_valid_next = ~flush;
                    if (strobe) begin
                        instruction_next = mem_data;
                        instr_valid_next = 1'b1;
                        state_next       = HOLD;
                    end else begin
                        instr_valid_next = 1'b0;
                        state_next       = IDLE;
                    end
                end else if (timeout) begin
                    mem_req_next     = 1'b0;
                    instruction_next = NOP_OPCODE;
                    instr_valid_next = 1'b1;
                    state_next       = HOLD;
                end else begin
                    wait_count_next = wait_count + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Self-checking bench for rom_fetch_unit: directed scenarios plus a randomized
// fetch sequence checked against a transaction-level tag/ROM model.
module tb_rom_fetch_unit;

    localparam int         WAIT_TIMEOUT = 15;
    localparam logic [7:0] NOP          = 8'h00;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] program_addr = 16'h0000;
    logic        rom_cs = 1'b0, rom_rd = 1'b0, eoi = 1'b0, flush = 1'b0;
    logic [7:0]  instruction;
    logic        instr_valid, busy, mem_req, fetch_err;
    logic [15:0] mem_addr, instr_count;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;

    int checks = 0;
    int failures = 0;

    // Behavioural model: ROM contents, the one-entry tag and the visible byte.
    logic [7:0]  rom_m [8];
    logic [15:0] tag_addr_m, last_addr_m, count_m;
    logic [7:0]  tag_data_m, inst_m;
    logic        tag_valid_m;

    rom_fetch_unit #(.WAIT_TIMEOUT(WAIT_TIMEOUT), .NOP_OPCODE(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .program_addr(program_addr),
        .rom_cs(rom_cs), .rom_rd(rom_rd), .eoi(eoi), .flush(flush),
        .instruction(instruction), .instr_valid(instr_valid), .busy(busy),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_data(mem_data), .instr_count(instr_count), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ROM side: request already visible; acks in the delay-th request cycle.
    task automatic rom_serve(input int delay, input logic [7:0] data, output int seen);
        seen = (mem_req === 1'b1) ? 1 : 0;
        for (int i = 1; i < delay; i++) begin
            step();
            if (mem_req === 1'b1) seen++;
        end
        mem_ack  = 1'b1;
        mem_data = data;
        step();
        mem_ack  = 1'b0;
        mem_data = 8'($urandom);
    endtask

    task automatic pulse_eoi();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        step();
        count_m = count_m + 16'd1;
    endtask

    task automatic model_reset();
        tag_valid_m = 1'b0;
        tag_addr_m  = 16'h0000;
        tag_data_m  = 8'h00;
        last_addr_m = 16'h0000;
        inst_m      = NOP;
        count_m     = 16'h0000;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++;
        if ({instruction, instr_valid, busy, mem_req, mem_addr, instr_count, fetch_err} !==
            {NOP, 3'b000, 16'h0000, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL reset_values: got %h expected %h",
                     {instruction, instr_valid, busy, mem_req, mem_addr, instr_count, fetch_err},
                     {NOP, 3'b000, 16'h0000, 16'h0000, 1'b0});
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step();
    endtask

    task automatic test_miss();
        int n;
        program_addr = 16'h0010;
        rom_cs = 1'b1;
        rom_rd = 1'b1;
        step();
        checks++;
        if ({mem_req, busy, mem_addr, instr_valid} !== {2'b11, 16'h0010, 1'b0}) begin
            failures++;
            $display("FAIL miss_issue: got %h expected %h",
                     {mem_req, busy, mem_addr, instr_valid}, {2'b11, 16'h0010, 1'b0});
        end
        rom_serve(3, 8'hA5, n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL miss_req_cycles: got %0d expected 3", n);
        end
        checks++;
        if ({mem_req, busy, instr_valid, instruction} !== {3'b001, 8'hA5}) begin
            failures++;
            $display("FAIL miss_result: got %h expected %h",
                     {mem_req, busy, instr_valid, instruction}, {3'b001, 8'hA5});
        end
        tag_valid_m = 1'b1; tag_addr_m = 16'h0010; tag_data_m = 8'hA5;
        inst_m = 8'hA5; last_addr_m = 16'h0010;
    endtask

    task automatic test_hit();
        int n;
        rom_rd = 1'b0;
        step();
        checks++;
        if ({instr_valid, instruction} !== {1'b0, inst_m}) begin
            failures++;
            $display("FAIL hold_release: got %h expected %h",
                     {instr_valid, instruction}, {1'b0, inst_m});
        end
        rom_rd = 1'b1;
        step();
        checks++;
        if ({mem_req, instr_valid, instruction} !== {2'b01, tag_data_m}) begin
            failures++;
            $display("FAIL hit_result: got %h expected %h",
                     {mem_req, instr_valid, instruction}, {2'b01, tag_data_m});
        end
        rom_rd = 1'b0;
        step();
        rom_rd = 1'b1;
        flush  = 1'b1;
        step();
        flush  = 1'b0;
        checks++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0010, 1'b0}) begin
            failures++;
            $display("FAIL flush_forces_miss: got %h expected %h",
                     {mem_req, mem_addr, instr_valid}, {1'b1, 16'h0010, 1'b0});
        end
        rom_serve(2, 8'hA5, n);
        checks++;
        if ({n[3:0], instr_valid, instruction} !== {4'd2, 1'b1, 8'hA5}) begin
            failures++;
            $display("FAIL flush_refetch: got %h expected %h",
                     {n[3:0], instr_valid, instruction}, {4'd2, 1'b1, 8'hA5});
        end
    endtask

    task automatic test_addr_change();
        int n;
        program_addr = 16'h0011;
        step();
        checks++;
        if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0011, 1'b0}) begin
            failures++;
            $display("FAIL addr_change_issue: got %h expected %h",
                     {mem_req, mem_addr, instr_valid}, {1'b1, 16'h0011, 1'b0});
        end
        rom_serve(2, 8'h3C, n);
        checks++;
        if ({n[3:0], mem_req, instr_valid, instruction} !== {4'd2, 2'b01, 8'h3C}) begin
            failures++;
            $display("FAIL addr_change_result: got %h expected %h",
                     {n[3:0], mem_req, instr_valid, instruction}, {4'd2, 2'b01, 8'h3C});
        end
        tag_addr_m = 16'h0011; tag_data_m = 8'h3C; inst_m = 8'h3C; last_addr_m = 16'h0011;
    endtask

    task automatic test_timeout();
        int n = 0;
        rom_rd = 1'b0;
        step();
        program_addr = 16'h0020;
        rom_rd = 1'b1;
        step();
        while (mem_req === 1'b1 && n < 100) begin
            n++;
            step();
        end
        checks++;
        if (n != WAIT_TIMEOUT) begin
            failures++;
            $display("FAIL timeout_req_cycles: got %0d expected %0d", n, WAIT_TIMEOUT);
        end
        checks++;
        if ({mem_req, busy, fetch_err, instr_valid, instruction} !== {4'b0011, NOP}) begin
            failures++;
            $display("FAIL timeout_result: got %h expected %h",
                     {mem_req, busy, fetch_err, instr_valid, instruction}, {4'b0011, NOP});
        end
        pulse_eoi();
        checks++;
        if ({fetch_err, instr_count} !== {1'b0, count_m}) begin
            failures++;
            $display("FAIL eoi_clears_err: got %h expected %h",
                     {fetch_err, instr_count}, {1'b0, count_m});
        end
        // The timed-out fetch must not have disturbed the held tag.
        rom_rd = 1'b0;
        step();
        program_addr = 16'h0011;
        rom_rd = 1'b1;
        step();
        checks++;
        if ({mem_req, instr_valid, instruction} !== {2'b01, tag_data_m}) begin
            failures++;
            $display("FAIL timeout_tag_kept: got %h expected %h",
                     {mem_req, instr_valid, instruction}, {2'b01, tag_data_m});
        end
        inst_m = tag_data_m; last_addr_m = 16'h0011;
    endtask

    task automatic test_strobe_drop();
        rom_rd = 1'b0;
        step();
        program_addr = 16'h0030;
        rom_rd = 1'b1;
        step();
        rom_rd = 1'b0;
        step();
        checks++;
        if ({mem_req, instr_valid} !== 2'b10) begin
            failures++;
            $display("FAIL drop_keeps_req: got %b expected 10", {mem_req, instr_valid});
        end
        step();
        mem_ack  = 1'b1;
        mem_data = 8'h77;
        step();
        mem_ack  = 1'b0;
        checks++;
        if ({mem_req, busy, instr_valid, instruction} !== {3'b000, inst_m}) begin
            failures++;
            $display("FAIL drop_completion: got %h expected %h",
                     {mem_req, busy, instr_valid, instruction}, {3'b000, inst_m});
        end
        rom_rd = 1'b1;
        step();
        checks++;
        if ({mem_req, instr_valid, instruction} !== {2'b01, 8'h77}) begin
            failures++;
            $display("FAIL drop_then_hit: got %h expected %h",
                     {mem_req, instr_valid, instruction}, {2'b01, 8'h77});
        end
        tag_valid_m = 1'b1; tag_addr_m = 16'h0030; tag_data_m = 8'h77;
        inst_m = 8'h77; last_addr_m = 16'h0030;
    endtask

    task automatic test_random();
        logic [15:0] addr;
        logic [7:0]  rom_byte;
        logic        fl, drop, trig, hit, eoi_prev;
        int          n, delay;
        for (int i = 0; i < 8; i++) rom_m[i] = 8'($urandom);
        eoi_prev = eoi;
        for (int it = 0; it < 40; it++) begin
            drop = 1'($urandom_range(0, 1));
            if (drop) begin
                rom_rd = 1'b0;
                step();
            end
            addr     = 16'h0040 + 16'($urandom_range(0, 7));
            rom_byte = rom_m[addr[2:0]];
            fl       = ($urandom_range(0, 3) == 0);
            program_addr = addr;
            rom_rd = 1'b1;
            flush  = fl;
            eoi    = 1'($urandom_range(0, 1));
            if (eoi && !eoi_prev) count_m = count_m + 16'd1;
            eoi_prev = eoi;
            step();
            flush = 1'b0;

            trig = drop || (addr != last_addr_m);
            if (fl) tag_valid_m = 1'b0;
            hit = tag_valid_m && (addr == tag_addr_m);
            checks++;
            if (!trig) begin
                if ({mem_req, instr_valid, instruction} !== {2'b01, inst_m}) begin
                    failures++;
                    $display("FAIL rand_no_trigger it=%0d: got %h expected %h", it,
                             {mem_req, instr_valid, instruction}, {2'b01, inst_m});
                end
            end else if (hit) begin
                if ({mem_req, instr_valid, instruction} !== {2'b01, rom_byte}) begin
                    failures++;
                    $display("FAIL rand_hit it=%0d: got %h expected %h", it,
                             {mem_req, instr_valid, instruction}, {2'b01, rom_byte});
                end
                inst_m = rom_byte;
            end else begin
                if ({mem_req, mem_addr, instr_valid} !== {1'b1, addr, 1'b0}) begin
                    failures++;
                    $display("FAIL rand_miss_issue it=%0d: got %h expected %h", it,
                             {mem_req, mem_addr, instr_valid}, {1'b1, addr, 1'b0});
                end
                delay = $urandom_range(1, 6);
                rom_serve(delay, rom_byte, n);
                checks++;
                if ({n[3:0], mem_req, instr_valid, instruction} !==
                    {delay[3:0], 2'b01, rom_byte}) begin
                    failures++;
                    $display("FAIL rand_miss_result it=%0d: got %h expected %h", it,
                             {n[3:0], mem_req, instr_valid, instruction},
                             {delay[3:0], 2'b01, rom_byte});
                end
                tag_valid_m = 1'b1; tag_addr_m = addr; tag_data_m = rom_byte;
                inst_m = rom_byte;
            end
            if (trig) last_addr_m = addr;
            checks++;
            if (instr_count !== count_m) begin
                failures++;
                $display("FAIL rand_count it=%0d: got %h expected %h", it, instr_count, count_m);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        int n;
        eoi = 1'b0;
        rom_rd = 1'b0;
        step();
        program_addr = 16'h0050;
        rom_rd = 1'b1;
        step();
        checks++;
        if (mem_req !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_setup: got %b expected 1", mem_req);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({instruction, instr_valid, busy, mem_req, mem_addr, instr_count, fetch_err} !==
            {NOP, 3'b000, 16'h0000, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid_values: got %h expected %h",
                     {instruction, instr_valid, busy, mem_req, mem_addr, instr_count, fetch_err},
                     {NOP, 3'b000, 16'h0000, 16'h0000, 1'b0});
        end
        rom_rd   = 1'b0;
        mem_ack  = 1'b1;
        mem_data = 8'hEE;
        step();
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        step();
        mem_ack = 1'b0;
        checks++;
        if ({mem_req, instr_valid, instruction, fetch_err} !== {2'b00, NOP, 1'b0}) begin
            failures++;
            $display("FAIL late_ack_ignored: got %h expected %h",
                     {mem_req, instr_valid, instruction, fetch_err}, {2'b00, NOP, 1'b0});
        end
        rom_rd = 1'b1;
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0050}) begin
            failures++;
            $display("FAIL post_reset_miss: got %h expected %h",
                     {mem_req, mem_addr}, {1'b1, 16'h0050});
        end
        rom_serve(1, 8'h5A, n);
        checks++;
        if ({instr_valid, instruction} !== {1'b1, 8'h5A}) begin
            failures++;
            $display("FAIL post_reset_fetch: got %h expected %h",
                     {instr_valid, instruction}, {1'b1, 8'h5A});
        end
    endtask

    task automatic test_count_wrap();
        for (int i = 0; i < 20; i++) pulse_eoi();
        checks++;
        if (instr_count !== count_m) begin
            failures++;
            $display("FAIL count_pulses: got %h expected %h", instr_count, count_m);
        end
        // Preload near the top instead of stepping through 65k pulses.
        force dut.instr_count = 16'hFFFE;
        step();
        step();
        release dut.instr_count;
        step();
        count_m = 16'hFFFE;
        checks++;
        if (instr_count !== count_m) begin
            failures++;
            $display("FAIL count_preload: got %h expected %h", instr_count, count_m);
        end
        pulse_eoi();
        checks++;
        if (instr_count !== 16'hFFFF) begin
            failures++;
            $display("FAIL count_top: got %h expected ffff", instr_count);
        end
        pulse_eoi();
        checks++;
        if (instr_count !== 16'h0000) begin
            failures++;
            $display("FAIL count_wrap: got %h expected 0000", instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_addr_change();
        test_timeout();
        test_strobe_drop();
        test_random();
        test_reset_mid_req();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
